// File: rtl/store_monitor_if.sv
// rtl/store_monitor_if.sv - store bus and log-drain port bundle for store_monitor
interface store_monitor_if #(
    parameter int DEPTH = 8
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic          MemWrite;
    logic [31:0]   DataAdr;
    logic [31:0]   WriteData;
    logic          pop;
    logic          rd_valid;
    logic [31:0]   rd_addr;
    logic [31:0]   rd_data;
    logic [31:0]   rd_cycle;
    logic [FW-1:0] fill;
    logic          overflow;
    logic [31:0]   cycle_count;
    logic          done;
    logic          pass;
    logic          timeout;

    modport master (
        output MemWrite, DataAdr, WriteData, pop,
        input  rd_valid, rd_addr, rd_data, rd_cycle, fill, overflow,
        input  cycle_count, done, pass, timeout
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, pop,
        output rd_valid, rd_addr, rd_data, rd_cycle, fill, overflow,
        output cycle_count, done, pass, timeout
    );
endinterface

// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - store capture log with done-address verdict and run timeout
module store_monitor #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] DONE_ADDR  = 32'h0000_0064,
    parameter logic [31:0] PASS_VALUE = 32'h0000_0019,
    parameter int          TIMEOUT    = 500
) (
    input logic           clk,
    input logic           reset,
    store_monitor_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    typedef enum logic [1:0] {RUN, PASS, FAIL, TMO} state_t;

    state_t        state_q, state_d;
    logic [31:0]   cycle_q;
    logic [31:0]   stamp;
    logic [31:0]   mem_addr  [DEPTH];
    logic [31:0]   mem_data  [DEPTH];
    logic [31:0]   mem_cycle [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [FW-1:0] fill_q;
    logic [31:0]   head_addr, head_data, head_cycle;
    logic          overflow_q;
    logic          running, capture, pop_ok, full, do_push, drop;

    // stamp is the 1-based number of the edge currently being evaluated
    assign running = (state_q == RUN);
    assign stamp   = cycle_q + 32'd1;
    assign capture = running && bus.MemWrite;
    assign pop_ok  = bus.pop && (fill_q != '0);
    assign full    = (fill_q == FW'(DEPTH));
    assign do_push = capture && (!full || pop_ok);
    assign drop    = capture && full && !pop_ok;
    assign rd_next = rd_ptr + AW'(1);

    // verdict decision; a done store on the timeout edge takes priority
    always_comb begin
        state_d = state_q;
        if (state_q == RUN) begin
            if (bus.MemWrite && (bus.DataAdr == DONE_ADDR)) begin
                state_d = (bus.WriteData == PASS_VALUE) ? PASS : FAIL;
            end else if (stamp == 32'(TIMEOUT)) begin
                state_d = TMO;
            end
        end
    end

    // state register and run cycle counter, frozen once a verdict exists
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            if (running) begin
                cycle_q <= stamp;
            end
        end
    end

    // log storage; only slots between rd_ptr and wr_ptr are ever read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_addr[wr_ptr]  <= bus.DataAdr;
            mem_data[wr_ptr]  <= bus.WriteData;
            mem_cycle[wr_ptr] <= stamp;
        end
    end

    // pointers, occupancy, sticky overflow and the registered show-ahead head
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            head_addr  <= '0;
            head_data  <= '0;
            head_cycle <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_next;
            end
            if (do_push && !pop_ok) begin
                fill_q <= fill_q + FW'(1);
            end else if (!do_push && pop_ok) begin
                fill_q <= fill_q - FW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            // head follows the next stored entry, or the incoming one when the
            // log is (or is about to become) empty; otherwise it holds
            if (pop_ok && (fill_q > FW'(1))) begin
                head_addr  <= mem_addr[rd_next];
                head_data  <= mem_data[rd_next];
                head_cycle <= mem_cycle[rd_next];
            end else if (do_push && ((fill_q == '0) || (pop_ok && (fill_q == FW'(1))))) begin
                head_addr  <= bus.DataAdr;
                head_data  <= bus.WriteData;
                head_cycle <= stamp;
            end
        end
    end

    assign bus.rd_valid    = (fill_q != '0);
    assign bus.rd_addr     = head_addr;
    assign bus.rd_data     = head_data;
    assign bus.rd_cycle    = head_cycle;
    assign bus.fill        = fill_q;
    assign bus.overflow    = overflow_q;
    assign bus.cycle_count = cycle_q;
    assign bus.done        = (state_q != RUN);
    assign bus.pass        = (state_q == PASS);
    assign bus.timeout     = (state_q == TMO);
endmodule

// File: doc/store_monitor.md
Name: store_monitor

Overview:
- Bus-side responder to the processor's data-store interface (MemWrite/DataAdr/WriteData) that `top` drives.
- Each clock it captures every store into a cycle-stamped FIFO that the bench or a debug port can drain through a valid/pop handshake.
- It detects the end-of-program store to a fixed "done" address, judges the stored value as pass or fail, and enforces a cycle timeout.
- The FSM stops capturing once the run ends.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2
DONE_ADDR, 32'h0000_0064, store address that ends the run
PASS_VALUE, 32'h0000_0019, value at DONE_ADDR meaning pass
TIMEOUT, 500, cycles allowed before a timeout verdict; at least 1

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
MemWrite  in  1  store strobe from the processor, one store per high cycle
DataAdr  in  32  store address
WriteData  in  32  store data
pop  in  1  consumer accepts the FIFO head
rd_valid  out  1  FIFO not empty; rd_* fields are valid
rd_addr  out  32  head entry address
rd_data  out  32  head entry data
rd_cycle  out  32  head entry cycle stamp
fill  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a store was dropped because the FIFO was full
cycle_count  out  32  run cycles elapsed
done  out  1  a verdict has been reached (PASS, FAIL or TMO)
pass  out  1  verdict is pass
timeout  out  1  verdict is timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - state = RUN; FIFO empty; fill = 0.
  - rd_valid = 0; rd_addr, rd_data and rd_cycle = 0.
  - overflow = 0; cycle_count = 0; done, pass and timeout = 0.
  - Asserting reset mid-run discards all entries and the verdict immediately.
- FSM states: RUN, PASS, FAIL, TMO. PASS, FAIL and TMO are terminal until reset.
- In RUN, at each edge:
  - cycle_count += 1.
  - Define stamp = cycle_count + 1, i.e. the 1-based cycle number of this edge.
  - If MemWrite=1 and DataAdr == DONE_ADDR, go to PASS when WriteData == PASS_VALUE, otherwise go to FAIL.
  - Else if stamp == TIMEOUT, go to TMO.
  - A done store on the same edge as the timeout wins over the timeout.
- In terminal states:
  - cycle_count freezes and no stores are captured.
  - Popping continues to work, so the log can be drained after the run.
- Outputs:
  - done = (state != RUN).
  - pass = (state == PASS).
  - timeout = (state == TMO).
  - All three are registered, so they are visible the cycle after the deciding edge.
- Capture:
  - In RUN with MemWrite=1, push {DataAdr, WriteData, stamp}.
  - The done store itself is captured.
- FIFO:
  - Show-ahead: rd_* always reflect the head entry. Write latency is 1 cycle, so an entry pushed at edge N has rd_valid=1 after edge N.
  - Pop takes effect only when pop=1 and rd_valid=1. Pop on empty is ignored, with no state change.
  - Push when fill == DEPTH and no pop: the entry is dropped, overflow is set (sticky), and fill is unchanged.
  - Push and pop on the same edge when full: both occur, fill stays DEPTH, and no overflow.
  - Push and pop on the same edge when fill == 1: the new entry becomes the head and rd_valid stays 1.
  - Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- rd_* hold their last values when empty; rd_valid qualifies them.

Test Plan:
1. Reset, then stores to 0x60 (val 7) and 0x64 (val 25) on cycles 3 and 5. Required: two entries {0x60,7,3} and {0x64,25,5}; pass=1 and done=1 after cycle 5; cycle_count frozen at 5.
2. Store to 0x64 with value 24 on cycle 4. Required: done=1, pass=0, timeout=0; a later store on cycle 6 is not captured and fill stays 1.
3. TIMEOUT=20 and no store to DONE_ADDR. Required: after cycle 20, timeout=1 and cycle_count=20. Variant: a done store on cycle 20 gives pass=1 and timeout=0.
4. DEPTH=8, 10 consecutive stores with pop=0. Required: fill=8, overflow=1, entries hold stores 1–8. Then 8 pops drain them in order and rd_valid=0.
5. FIFO full with push and pop on the same edge. Required: fill stays 8, overflow remains 0, and the head advances. Also pop on empty: no change.
6. Assert reset=0 asynchronously mid-run with 3 entries and pass=1. Required: outputs clear immediately without waiting for a clk edge; after release, capture restarts with stamp 1.
